// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN bus levels, error-frame state encoding and default lengths
package can_pkg;

    localparam logic CAN_DOMINANT  = 1'b0;
    localparam logic CAN_RECESSIVE = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLAG     = 3'd1,
        WAIT_REC = 3'd2,
        DELIM    = 3'd3,
        INTERM   = 3'd4,
        BUSOFF   = 3'd5
    } ef_state_t;

    localparam int unsigned DEF_FLAG_LEN    = 6;
    localparam int unsigned DEF_DELIM_LEN   = 8;
    localparam int unsigned DEF_INTERM_LEN  = 3;
    localparam int unsigned DEF_DOM_LIMIT   = 14;
    localparam int unsigned DEF_BO_IDLE_LEN = 11;
    localparam int unsigned DEF_BO_SEQ_CNT  = 128;

    function automatic logic frame_state(input ef_state_t s);
        return (s == FLAG) || (s == WAIT_REC) || (s == DELIM) || (s == INTERM);
    endfunction

endpackage

// File: rtl/can_busoff_monitor.sv
// rtl/can_busoff_monitor.sv - counts recessive idle sequences during bus-off for recovery
module can_busoff_monitor
    import can_pkg::*;
#(
    parameter int unsigned BO_IDLE_LEN = DEF_BO_IDLE_LEN,
    parameter int unsigned BO_SEQ_CNT  = DEF_BO_SEQ_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic bit_tick,
    input  logic rx_bit,
    output logic busoff_recovered
);

    localparam logic [3:0] IDLE_LEN_C = 4'(BO_IDLE_LEN);
    localparam logic [7:0] SEQ_CNT_C  = 8'(BO_SEQ_CNT);

    logic [3:0] run_cnt;
    logic [7:0] seq_cnt;

    // Counters only live while enabled; leaving bus-off discards all progress.
    always_ff @(posedge clk) begin
        busoff_recovered <= 1'b0;
        if (rst || !en) begin
            run_cnt <= '0;
            seq_cnt <= '0;
        end else if (bit_tick) begin
            if (rx_bit == CAN_DOMINANT) begin
                run_cnt <= '0;
            end else if (run_cnt + 4'd1 == IDLE_LEN_C) begin
                run_cnt <= '0;
                if (seq_cnt != SEQ_CNT_C) begin
                    seq_cnt <= seq_cnt + 8'd1;
                    if (seq_cnt + 8'd1 == SEQ_CNT_C) begin
                        busoff_recovered <= 1'b1;
                    end
                end
            end else begin
                run_cnt <= run_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/error_frame_gen.sv
// rtl/error_frame_gen.sv - drives CAN error flag, delimiter and intermission; tracks bus-off
module error_frame_gen
    import can_pkg::*;
#(
    parameter int unsigned FLAG_LEN    = DEF_FLAG_LEN,
    parameter int unsigned DELIM_LEN   = DEF_DELIM_LEN,
    parameter int unsigned INTERM_LEN  = DEF_INTERM_LEN,
    parameter int unsigned DOM_LIMIT   = DEF_DOM_LIMIT,
    parameter int unsigned BO_IDLE_LEN = DEF_BO_IDLE_LEN,
    parameter int unsigned BO_SEQ_CNT  = DEF_BO_SEQ_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_tick,
    input  logic rx_bit,
    input  logic error_frame_req,
    input  logic error_passive,
    input  logic bus_off,
    output logic tx_bit,
    output logic ef_active,
    output logic error_frame_sent,
    output logic delim_error,
    output logic dom_overrun,
    output logic busoff_recovered
);

    localparam logic [3:0] FLAG_LEN_C   = 4'(FLAG_LEN);
    localparam logic [3:0] DELIM_LEN_C  = 4'(DELIM_LEN);
    localparam logic [3:0] INTERM_LEN_C = 4'(INTERM_LEN);
    localparam logic [3:0] DOM_LIMIT_C  = 4'(DOM_LIMIT);

    ef_state_t  state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] eq_cnt, eq_cnt_nxt;
    logic [3:0] dom_cnt, dom_cnt_nxt;
    logic       prev_rx, prev_rx_nxt;
    logic       mode_passive, mode_nxt;
    logic       tx_nxt;
    logic       sent_nxt, delim_err_nxt, dom_ovr_nxt;

    logic [3:0] cnt_inc;
    logic [3:0] dom_inc;
    logic [3:0] eq_run;

    assign cnt_inc = cnt + 4'd1;
    assign dom_inc = dom_cnt + 4'd1;
    // eq_cnt==0 means no bit sampled yet in this flag, so the first bit starts a run of one.
    assign eq_run  = ((eq_cnt != 4'd0) && (rx_bit == prev_rx)) ? eq_cnt + 4'd1 : 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            eq_cnt           <= '0;
            dom_cnt          <= '0;
            prev_rx          <= CAN_RECESSIVE;
            mode_passive     <= 1'b0;
            tx_bit           <= CAN_RECESSIVE;
            ef_active        <= 1'b0;
            error_frame_sent <= 1'b0;
            delim_error      <= 1'b0;
            dom_overrun      <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            eq_cnt           <= eq_cnt_nxt;
            dom_cnt          <= dom_cnt_nxt;
            prev_rx          <= prev_rx_nxt;
            mode_passive     <= mode_nxt;
            tx_bit           <= tx_nxt;
            ef_active        <= frame_state(state_nxt);
            error_frame_sent <= sent_nxt;
            delim_error      <= delim_err_nxt;
            dom_overrun      <= dom_ovr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        eq_cnt_nxt    = eq_cnt;
        dom_cnt_nxt   = dom_cnt;
        prev_rx_nxt   = prev_rx;
        mode_nxt      = mode_passive;
        tx_nxt        = tx_bit;
        sent_nxt      = 1'b0;
        delim_err_nxt = 1'b0;
        dom_ovr_nxt   = 1'b0;

        // bus_off abort does not wait for a bit tick.
        if (bus_off && (state != BUSOFF)) begin
            state_nxt   = BUSOFF;
            tx_nxt      = CAN_RECESSIVE;
            cnt_nxt     = '0;
            eq_cnt_nxt  = '0;
            dom_cnt_nxt = '0;
            sent_nxt    = frame_state(state);
        end else if (bit_tick) begin
            case (state)
                IDLE: begin
                    if (error_frame_req) begin
                        state_nxt  = FLAG;
                        mode_nxt   = error_passive;
                        tx_nxt     = error_passive ? CAN_RECESSIVE : CAN_DOMINANT;
                        cnt_nxt    = '0;
                        eq_cnt_nxt = '0;
                    end
                end
                FLAG: begin
                    if (!mode_passive) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == FLAG_LEN_C) begin
                            state_nxt   = WAIT_REC;
                            tx_nxt      = CAN_RECESSIVE;
                            cnt_nxt     = '0;
                            dom_cnt_nxt = '0;
                        end
                    end else begin
                        eq_cnt_nxt  = eq_run;
                        prev_rx_nxt = rx_bit;
                        if (eq_run == FLAG_LEN_C) begin
                            state_nxt   = WAIT_REC;
                            tx_nxt      = CAN_RECESSIVE;
                            eq_cnt_nxt  = '0;
                            dom_cnt_nxt = '0;
                        end
                    end
                end
                WAIT_REC: begin
                    if (rx_bit == CAN_RECESSIVE) begin
                        state_nxt   = DELIM;
                        cnt_nxt     = 4'd1;
                        dom_cnt_nxt = '0;
                    end else if (dom_inc == DOM_LIMIT_C) begin
                        dom_ovr_nxt = 1'b1;
                        dom_cnt_nxt = '0;
                    end else begin
                        dom_cnt_nxt = dom_inc;
                    end
                end
                DELIM: begin
                    if (rx_bit == CAN_RECESSIVE) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == DELIM_LEN_C) begin
                            state_nxt = INTERM;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        // Dominant in the delimiter restarts a fresh flag without reporting completion.
                        delim_err_nxt = 1'b1;
                        state_nxt     = FLAG;
                        mode_nxt      = error_passive;
                        tx_nxt        = error_passive ? CAN_RECESSIVE : CAN_DOMINANT;
                        cnt_nxt       = '0;
                        eq_cnt_nxt    = '0;
                    end
                end
                INTERM: begin
                    cnt_nxt = cnt_inc;
                    if ((cnt_inc == INTERM_LEN_C) || (rx_bit == CAN_DOMINANT)) begin
                        sent_nxt  = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                BUSOFF: begin
                    if (!bus_off) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    tx_nxt    = CAN_RECESSIVE;
                end
            endcase
        end
    end

    can_busoff_monitor #(
        .BO_IDLE_LEN(BO_IDLE_LEN),
        .BO_SEQ_CNT (BO_SEQ_CNT)
    ) u_busoff_monitor (
        .clk             (clk),
        .rst             (rst),
        .en              ((state == BUSOFF) && bus_off),
        .bit_tick        (bit_tick),
        .rx_bit          (rx_bit),
        .busoff_recovered(busoff_recovered)
    );

endmodule
